// File: rtl/tm1640_display_if.sv
// Control and bus bundle for tm1640_display: frame request, frame status, the
// two-wire TM1640 bus, and the frame FSM state for observation.
interface tm1640_display_if;
   logic       update;
   logic       busy;
   logic       frame_done;
   logic       tm_clk;
   logic       tm_din;
   logic [1:0] state_dbg;

   modport master (
      output update,
      input  busy, frame_done, tm_clk, tm_din, state_dbg
   );

   modport slave (
      input  update,
      output busy, frame_done, tm_clk, tm_din, state_dbg
   );
endinterface

// File: rtl/tm1640_display.sv
// TM1640 frame controller: snapshots up to 16 digit positions and streams
// complete frames through the tm1640 byte driver on request or on refresh.

// Byte handshake: data_in/data_stop_bit are held stable while data_latch is
// high; the driver accepts when idle and raises busy the next cycle; the
// requester drops data_latch once it sees busy and waits for busy to fall.
module tm1640 #(
   parameter int CLK_FREQ = 10_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       data_stop_bit,
   input  logic       data_latch,
   output logic       busy,
   output logic       tm_clk,
   output logic       tm_din
);
   // One bus half-period per microsecond keeps tm_clk at or below 500 kHz.
   localparam int HALF_RAW = CLK_FREQ / 1_000_000;
   localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
   localparam int DIV_W    = (HALF > 1) ? $clog2(HALF) : 1;

   typedef enum logic [2:0] {
      D_IDLE, D_START, D_LOW, D_HIGH, D_TAIL, D_STOP1, D_STOP2
   } drv_state_t;

   drv_state_t       state_q, state_d;
   logic [7:0]       sr_q, sr_d;
   logic             stop_q, stop_d;
   logic [2:0]       bit_q, bit_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             open_q, open_d;
   logic             clk_q, clk_d;
   logic             din_q, din_d;
   logic             tick;

   assign tick   = (div_q == DIV_W'(HALF - 1));
   assign busy   = (state_q != D_IDLE);
   assign tm_clk = clk_q;
   assign tm_din = din_q;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      stop_d  = stop_q;
      bit_d   = bit_q;
      open_d  = open_q;
      clk_d   = clk_q;
      din_d   = din_q;
      div_d   = (state_q == D_IDLE || tick) ? '0 : div_q + DIV_W'(1);
      case (state_q)
         D_IDLE: if (data_latch) begin
            sr_d   = data_in;
            stop_d = data_stop_bit;
            bit_d  = '0;
            // Bytes following a stop-less byte continue without a new start.
            if (open_q) begin
               state_d = D_LOW;
               din_d   = data_in[0];
            end else begin
               state_d = D_START;
               din_d   = 1'b0;
            end
         end
         D_START: if (tick) begin
            state_d = D_LOW;
            clk_d   = 1'b0;
            din_d   = sr_q[0];
            open_d  = 1'b1;
         end
         D_LOW: if (tick) begin
            state_d = D_HIGH;
            clk_d   = 1'b1;
         end
         D_HIGH: if (tick) begin
            clk_d = 1'b0;
            if (bit_q == 3'd7) begin
               state_d = D_TAIL;
               if (stop_q) din_d = 1'b0;
            end else begin
               bit_d   = bit_q + 3'd1;
               sr_d    = {1'b0, sr_q[7:1]};
               din_d   = sr_q[1];
               state_d = D_LOW;
            end
         end
         D_TAIL: if (tick) begin
            if (stop_q) begin
               state_d = D_STOP1;
               clk_d   = 1'b1;
            end else begin
               state_d = D_IDLE;
            end
         end
         D_STOP1: if (tick) begin
            din_d   = 1'b1;
            open_d  = 1'b0;
            state_d = D_STOP2;
         end
         D_STOP2: if (tick) state_d = D_IDLE;
         default: state_d = D_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= D_IDLE;
         sr_q    <= '0;
         stop_q  <= 1'b0;
         bit_q   <= '0;
         div_q   <= '0;
         open_q  <= 1'b0;
         clk_q   <= 1'b1;
         din_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         stop_q  <= stop_d;
         bit_q   <= bit_d;
         div_q   <= div_d;
         open_q  <= open_d;
         clk_q   <= clk_d;
         din_q   <= din_d;
      end
   end
endmodule

module tm1640_display #(
   parameter int SYSTEM_CLK = 10_000_000,
   parameter int DIGITS     = 9,
   parameter int REFRESH_HZ = 50
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   digits,
   input  logic [8*DIGITS-1:0]   raw_seg,
   input  logic                  raw_mode,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blank,
   input  logic [2:0]            brightness,
   input  logic                  display_on,
   tm1640_display_if.slave       bus
);
   localparam bit REFRESH_EN = (REFRESH_HZ > 0);
   localparam int RELOAD     = REFRESH_EN ? SYSTEM_CLK / REFRESH_HZ : 2;
   localparam int REF_W      = (RELOAD > 1) ? $clog2(RELOAD) : 1;
   localparam int IDX_W      = 5;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS + 2);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACK, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             latch_q, latch_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pending_q, pending_d;
   logic             init_q, init_d;
   logic [REF_W-1:0] ref_q, ref_d;
   logic [7:0]       snap_q [DIGITS];
   logic [7:0]       snap_d [DIGITS];
   logic [7:0]       ctrl_q, ctrl_d;
   logic [7:0]       pos_byte [DIGITS];
   logic [7:0]       cur_byte;
   logic             cur_stop;
   logic             start_frame, trigger, expiry;
   logic             drv_rst, drv_busy, drv_clk, drv_din;

   function automatic logic [7:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: hex_seg = 8'h3F;  4'h1: hex_seg = 8'h06;
         4'h2: hex_seg = 8'h5B;  4'h3: hex_seg = 8'h4F;
         4'h4: hex_seg = 8'h66;  4'h5: hex_seg = 8'h6D;
         4'h6: hex_seg = 8'h7D;  4'h7: hex_seg = 8'h07;
         4'h8: hex_seg = 8'h7F;  4'h9: hex_seg = 8'h6F;
         4'hA: hex_seg = 8'h77;  4'hB: hex_seg = 8'h7C;
         4'hC: hex_seg = 8'h39;  4'hD: hex_seg = 8'h5E;
         4'hE: hex_seg = 8'h79;  default: hex_seg = 8'h71;
      endcase
   endfunction

   always_comb begin
      for (int i = 0; i < DIGITS; i++) begin
         if (blank[i]) pos_byte[i] = 8'h00;
         else pos_byte[i] = (raw_mode ? raw_seg[8*i +: 8] : hex_seg(digits[4*i +: 4]))
                            | {dp[i], 7'b0};
      end
   end

   always_comb begin
      cur_byte = ctrl_q;
      cur_stop = 1'b1;
      if (idx_q == '0) begin
         cur_byte = 8'h40;
      end else if (idx_q == IDX_W'(1)) begin
         cur_byte = 8'hC0;
         cur_stop = 1'b0;
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IDX_W'(i + 2)) begin
            cur_byte = snap_q[i];
            cur_stop = (i == DIGITS - 1);
         end
      end
   end

   assign expiry  = REFRESH_EN && (ref_q == '0);
   assign trigger = bus.update || expiry || init_q;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      latch_d     = latch_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      pending_d   = pending_q;
      init_d      = init_q;
      snap_d      = snap_q;
      ctrl_d      = ctrl_q;
      start_frame = 1'b0;
      // Counter parks at zero so a late expiry still reads as a trigger.
      ref_d       = (ref_q == '0) ? ref_q : ref_q - REF_W'(1);
      case (state_q)
         S_IDLE: if (trigger || pending_q) start_frame = 1'b1;
         S_LOAD: begin
            latch_d = 1'b1;
            state_d = S_ACK;
         end
         S_ACK: if (drv_busy) begin
            latch_d = 1'b0;
            state_d = S_DONE;
         end
         S_DONE: if (!drv_busy) begin
            if (idx_q == LAST_IDX) begin
               done_d = 1'b1;
               if (trigger || pending_q) start_frame = 1'b1;
               else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = S_LOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (start_frame) begin
         state_d   = S_LOAD;
         busy_d    = 1'b1;
         idx_d     = '0;
         pending_d = 1'b0;
         init_d    = 1'b0;
         ref_d     = REF_W'(RELOAD - 1);
         snap_d    = pos_byte;
         ctrl_d    = {4'b1000, display_on, brightness};
      end else if (trigger) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         latch_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pending_q <= 1'b0;
         init_q    <= 1'b1;
         ref_q     <= REF_W'(RELOAD - 1);
         ctrl_q    <= '0;
         for (int i = 0; i < DIGITS; i++) snap_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         latch_q   <= latch_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pending_q <= pending_d;
         init_q    <= init_d;
         ref_q     <= ref_d;
         ctrl_q    <= ctrl_d;
         snap_q    <= snap_d;
      end
   end

   assign drv_rst = ~rst_n;

   tm1640 #(.CLK_FREQ(SYSTEM_CLK)) u_drv (
      .clk          (clk),
      .rst          (drv_rst),
      .data_in      (cur_byte),
      .data_stop_bit(cur_stop),
      .data_latch   (latch_q),
      .busy         (drv_busy),
      .tm_clk       (drv_clk),
      .tm_din       (drv_din)
   );

   assign bus.busy       = busy_q;
   assign bus.frame_done = done_q;
   assign bus.tm_clk     = drv_clk;
   assign bus.tm_din     = drv_din;
   assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_tm1640_display.sv
// Bench for tm1640_display: bus tokens decoded from tm_clk/tm_din are checked
// against an expected queue; a second instance exercises periodic refresh.
module tb_tm1640_display;
   localparam int DIG = 9;
   localparam logic [8:0] STOP = 9'h100;
   localparam logic [8*DIG-1:0] FRAME_A   = 72'h6F_7F_07_7D_6D_66_4F_5B_06;
   localparam logic [8*DIG-1:0] FRAME_RAW = 72'h18_17_16_15_14_13_12_00_D5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst_n_r = 1'b0;
   logic [4*DIG-1:0] digits;
   logic [8*DIG-1:0] raw_seg;
   logic             raw_mode;
   logic [DIG-1:0]   dp, blank;
   logic [2:0]       brightness;
   logic             display_on;

   int tests = 0;
   int fails = 0;
   int tok_cnt = 0;
   int done_cnt = 0;
   int cyc = 0;
   int starts_r[$];
   logic r_done = 1'b0;
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   tm1640_display_if bus();
   tm1640_display_if bus_r();

   tm1640_display #(.SYSTEM_CLK(1_000_000), .DIGITS(DIG), .REFRESH_HZ(0)) dut (
      .clk(clk), .rst_n(rst_n), .digits(digits), .raw_seg(raw_seg),
      .raw_mode(raw_mode), .dp(dp), .blank(blank), .brightness(brightness),
      .display_on(display_on), .bus(bus)
   );

   tm1640_display #(.SYSTEM_CLK(1_000_000), .DIGITS(DIG), .REFRESH_HZ(1000)) dut_r (
      .clk(clk), .rst_n(rst_n_r), .digits(digits), .raw_seg(raw_seg),
      .raw_mode(raw_mode), .dp(dp), .blank(blank), .brightness(brightness),
      .display_on(display_on), .bus(bus_r)
   );

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic got_token(input logic [8:0] t);
      logic [8:0] e;
      tok_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL bus_token: got %0h, expected nothing", t);
      end else begin
         e = exp_q.pop_front();
         if (t !== e) begin
            fails++;
            $display("FAIL bus_token #%0d: got %0h, expected %0h", tok_cnt, t, e);
         end
      end
   endtask

   task automatic push_frame(input logic [8*DIG-1:0] pb, input logic [7:0] ctrl);
      exp_q.push_back(9'h040);
      exp_q.push_back(STOP);
      exp_q.push_back(9'h0C0);
      for (int i = 0; i < DIG; i++) exp_q.push_back({1'b0, pb[8*i +: 8]});
      exp_q.push_back(STOP);
      exp_q.push_back({1'b0, ctrl});
      exp_q.push_back(STOP);
   endtask

   task automatic pulse_update();
      bus.update = 1'b1;
      @(negedge clk);
      bus.update = 1'b0;
   endtask

   // Returns at the negedge where frame_done is seen; stayed_busy covers the wait.
   task automatic wait_done(input string name, output logic stayed_busy);
      int n;
      n = 0;
      stayed_busy = 1'b1;
      @(negedge clk);
      while (!bus.frame_done && n < 2000) begin
         stayed_busy &= bus.busy;
         @(negedge clk);
         n++;
      end
      tests++;
      if (!bus.frame_done) begin
         fails++;
         $display("FAIL %s: frame_done timeout after %0d cycles", name, n);
      end
   endtask

   // Bus decoder for the main instance.
   logic pc = 1'b1, pd = 1'b1;
   logic [7:0] sh = '0;
   int nb = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         pc = 1'b1;
         pd = 1'b1;
         nb = 0;
      end else begin
         if (bus.frame_done) done_cnt++;
         if (pc && bus.tm_clk && pd && !bus.tm_din) nb = 0;
         else if (pc && bus.tm_clk && !pd && bus.tm_din) got_token(STOP);
         else if (!pc && bus.tm_clk) begin
            sh = {bus.tm_din, sh[7:1]};
            nb++;
            if (nb == 8) begin
               got_token({1'b0, sh});
               nb = 0;
            end
         end
         pc = bus.tm_clk;
         pd = bus.tm_din;
      end
   end

   logic prev_busy_r = 1'b0;
   always @(negedge clk) begin
      if (bus_r.busy && !prev_busy_r) starts_r.push_back(cyc);
      prev_busy_r = bus_r.busy;
   end

   // Refresh instance: periodic starts, plus update coinciding with expiry.
   initial begin
      int n, tgt;
      bus_r.update = 1'b0;
      n = 0;
      while (starts_r.size() < 2 && n < 4000) begin @(negedge clk); n++; end
      check("refresh_second_start_seen", int'(starts_r.size() >= 2), 1);
      if (starts_r.size() >= 2) begin
         tgt = starts_r[1] + 999;
         while (cyc < tgt) @(negedge clk);
         bus_r.update = 1'b1;
         @(negedge clk);
         bus_r.update = 1'b0;
      end
      n = 0;
      while (starts_r.size() < 5 && n < 6000) begin @(negedge clk); n++; end
      check("refresh_five_starts", int'(starts_r.size() >= 5), 1);
      for (int i = 1; i < 5; i++)
         if (i < starts_r.size())
            check($sformatf("refresh_interval_%0d", i), starts_r[i] - starts_r[i-1], 1000);
      r_done = 1'b1;
   end

   initial begin
      logic sb;
      int base, n, d0;
      digits = 36'h987654321;
      raw_seg = {8'h18, 8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'hFF, 8'h55};
      raw_mode = 1'b0;
      dp = '0;
      blank = '0;
      brightness = 3'd4;
      display_on = 1'b1;
      bus.update = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_frame_done", bus.frame_done, 0);
      check("rst_tm_clk", bus.tm_clk, 1);
      check("rst_tm_din", bus.tm_din, 1);
      check("rst_state", bus.state_dbg, 0);

      // Automatic frame after reset release.
      push_frame(FRAME_A, 8'h8C);
      rst_n = 1'b1;
      rst_n_r = 1'b1;
      @(negedge clk);
      check("init_busy_rise", bus.busy, 1);
      check("init_state_load", bus.state_dbg, 1);
      @(negedge clk);
      check("init_state_ack", bus.state_dbg, 2);
      wait_done("init_frame", sb);
      check("init_busy_fall", bus.busy, 0);
      @(negedge clk);
      check("init_done_single", bus.frame_done, 0);
      check("init_done_cnt", done_cnt, 1);
      check("init_tokens_left", exp_q.size(), 0);

      // Raw mode with dp and blank.
      raw_mode = 1'b1;
      dp = 9'b000000011;
      blank = 9'b000000010;
      push_frame(FRAME_RAW, 8'h8C);
      pulse_update();
      wait_done("raw_frame", sb);
      @(negedge clk);
      check("raw_done_cnt", done_cnt, 2);
      check("raw_tokens_left", exp_q.size(), 0);

      // Brightness change mid-frame lands in the next frame only.
      raw_mode = 1'b0;
      dp = '0;
      blank = '0;
      push_frame(FRAME_A, 8'h8C);
      pulse_update();
      repeat (40) @(negedge clk);
      brightness = 3'd7;
      wait_done("bright_frame1", sb);
      push_frame(FRAME_A, 8'h8F);
      pulse_update();
      wait_done("bright_frame2", sb);
      @(negedge clk);
      check("bright_tokens_left", exp_q.size(), 0);

      // Three updates during a frame give exactly one queued frame.
      push_frame(FRAME_A, 8'h8F);
      push_frame(FRAME_A, 8'h8F);
      d0 = done_cnt;
      pulse_update();
      repeat (20) @(negedge clk);
      pulse_update();
      repeat (10) @(negedge clk);
      pulse_update();
      repeat (10) @(negedge clk);
      pulse_update();
      wait_done("pend_frame1", sb);
      check("pend_busy_held", bus.busy, 1);
      check("pend_restart_load", bus.state_dbg, 1);
      wait_done("pend_frame2", sb);
      check("pend_busy_across", sb, 1);
      check("pend_busy_fall", bus.busy, 0);
      repeat (50) @(negedge clk);
      check("pend_no_third", bus.busy, 0);
      check("pend_done_cnt", done_cnt, d0 + 2);
      check("pend_tokens_left", exp_q.size(), 0);

      // Reset during position byte 5, then a fresh full frame.
      exp_q.push_back(9'h040);
      exp_q.push_back(STOP);
      exp_q.push_back(9'h0C0);
      for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, FRAME_A[8*i +: 8]});
      base = tok_cnt;
      d0 = done_cnt;
      pulse_update();
      n = 0;
      while (tok_cnt < base + 8 && n < 1000) begin @(negedge clk); n++; end
      check("rst_mid_prefix_seen", tok_cnt - base, 8);
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_tm_clk", bus.tm_clk, 1);
      check("rst_mid_tm_din", bus.tm_din, 1);
      check("rst_mid_busy", bus.busy, 0);
      check("rst_mid_state", bus.state_dbg, 0);
      repeat (3) @(negedge clk);
      check("rst_mid_tokens_left", exp_q.size(), 0);
      push_frame(FRAME_A, 8'h8F);
      rst_n = 1'b1;
      wait_done("rst_fresh_frame", sb);
      @(negedge clk);
      check("rst_fresh_done_cnt", done_cnt, d0 + 1);
      check("rst_fresh_tokens_left", exp_q.size(), 0);

      n = 0;
      while (!r_done && n < 12000) begin @(negedge clk); n++; end
      check("refresh_process_finished", r_done, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
